// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared widths and row-accumulator state encodings
// Purpose : defaults shared by the CSR loader, multiplier and row accumulator,
//           plus the accumulator FSM state type.
// Ports   : none (package).
package spmv_pkg;

  localparam int ROW_W_DEF  = 10;
  localparam int PROD_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ZPEND = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/spmv_result_fifo.sv
// rtl/spmv_result_fifo.sv - synchronous first-word fall-through result FIFO
// Purpose : holds {row, sum} results until the consumer pops them.
// Ports   : clk, rst_n (async active-low)
//           wr_data/wr_en  push side; a push into a full FIFO is dropped
//           rd_data/rd_valid/rd_en  FWFT head, popped on rd_valid & rd_en
//           count          number of stored entries (0..DEPTH)
module spmv_result_fifo #(
  parameter int W     = 82,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     wr_data,
  input  logic             wr_en,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid,
  input  logic             rd_en,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_rd    = rd_en && (count != '0);
  assign do_wr    = wr_en && (count != DEPTH_C);
  assign rd_valid = (count != '0);
  // Head is forced to zero when empty so the output is defined out of reset.
  assign rd_data  = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spmv_row_accum.sv
// rtl/spmv_row_accum.sv - per-row product accumulator of the CSR SpMV pipeline
// Purpose : sums the two-lane product stream per matrix row and emits exactly
//           one {row, sum} result per row (empty rows yield an explicit zero).
// Config  : `define ACC_SAT_EN -> saturating accumulate and sticky ovf;
//           otherwise adds wrap modulo 2^ACC_W and ovf is tied to 0.
// Ports   : clk, reset (async active-low)
//           in_op1/in_op2 signed products, in_addr row, in_valid, in_zeros
//           (empty-row marker), in_last (final beat), in_ready
//           res_data/res_row/res_valid/res_ready result FIFO head
//           done one-cycle end-of-matrix pulse, err sticky row-went-backwards,
//           ovf sticky saturation flag
module spmv_row_accum
  import spmv_pkg::*;
#(
  parameter int PROD_W     = PROD_W_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int ACC_W      = 72,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] in_op1,
  input  logic [PROD_W-1:0] in_op2,
  input  logic [ROW_W-1:0]  in_addr,
  input  logic              in_valid,
  input  logic              in_zeros,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   zrow;
  logic [ACC_W-1:0]   acc;
  logic               has_open;
  logic               last_pend;
  logic               rdy_en;

  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic [ROW_W+ACC_W-1:0] fifo_rd;

  logic               accept;
  logic               same_row;
  logic [ACC_W-1:0]   beat_sum;
  logic [ACC_W-1:0]   add_res;
  logic               sat_hit;

  logic               push;
  logic [ROW_W-1:0]   push_row;
  logic [ACC_W-1:0]   push_sum;

  assign fifo_full = (fifo_cnt == DEPTH_C);
  // rdy_en keeps in_ready low while reset is held and for the first edge after.
  assign in_ready  = rdy_en && !fifo_full && (state == ST_IDLE || state == ST_ACCUM);
  assign accept    = in_valid && in_ready;
  assign same_row  = !in_zeros && (in_addr == row);

  // ACC_W > PROD_W, so the beat sum itself can never overflow.
  assign beat_sum = {{(ACC_W-PROD_W){in_op1[PROD_W-1]}}, in_op1}
                  + {{(ACC_W-PROD_W){in_op2[PROD_W-1]}}, in_op2};

  always_comb begin
    add_res = acc + beat_sum;
    sat_hit = 1'b0;
`ifdef ACC_SAT_EN
    // Signed overflow: operands agree in sign, result does not.
    if ((acc[ACC_W-1] == beat_sum[ACC_W-1]) && (add_res[ACC_W-1] != acc[ACC_W-1])) begin
      sat_hit = 1'b1;
      add_res = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // At most one result is pushed per cycle; ZPEND and FLUSH wait for space.
  always_comb begin
    push     = 1'b0;
    push_row = row;
    push_sum = acc;
    case (state)
      ST_IDLE: begin
        if (accept && in_zeros) begin
          push     = 1'b1;
          push_row = in_addr;
          push_sum = '0;
        end
      end
      ST_ACCUM: begin
        if (accept && !same_row) push = 1'b1;
      end
      ST_ZPEND: begin
        if (!fifo_full) begin
          push     = 1'b1;
          push_row = zrow;
          push_sum = '0;
        end
      end
      ST_FLUSH: begin
        if (has_open && !fifo_full) push = 1'b1;
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      row       <= '0;
      zrow      <= '0;
      acc       <= '0;
      has_open  <= 1'b0;
      last_pend <= 1'b0;
      rdy_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (in_zeros) begin
              has_open <= 1'b0;
              state    <= in_last ? ST_FLUSH : ST_IDLE;
            end else begin
              row      <= in_addr;
              acc      <= beat_sum;
              has_open <= 1'b1;
              state    <= in_last ? ST_FLUSH : ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (in_addr < row) err <= 1'b1;
            if (in_zeros) begin
              zrow      <= in_addr;
              has_open  <= 1'b0;
              last_pend <= in_last;
              state     <= ST_ZPEND;
            end else if (same_row) begin
              acc   <= add_res;
              state <= in_last ? ST_FLUSH : ST_ACCUM;
            end else begin
              // A backwards row is still closed and reopened like a new row.
              row   <= in_addr;
              acc   <= beat_sum;
              state <= in_last ? ST_FLUSH : ST_ACCUM;
            end
          end
        end
        ST_ZPEND: begin
          if (!fifo_full) begin
            last_pend <= 1'b0;
            state     <= last_pend ? ST_FLUSH : ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (!has_open || !fifo_full) begin
            has_open <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACC_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (state == ST_ACCUM && accept && same_row && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  spmv_result_fifo #(
    .W     (ROW_W + ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .wr_data  ({push_row, push_sum}),
    .wr_en    (push),
    .rd_data  (fifo_rd),
    .rd_valid (res_valid),
    .rd_en    (res_ready),
    .count    (fifo_cnt)
  );

  assign res_row  = fifo_rd[ROW_W+ACC_W-1:ACC_W];
  assign res_data = fifo_rd[ACC_W-1:0];

endmodule

// File: tb/tb_spmv_row_accum.sv
// tb/tb_spmv_row_accum.sv - directed self-checking bench for spmv_row_accum
module tb_spmv_row_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] op1 = '0, op2 = '0;
  logic [9:0]  addr = '0;
  logic        v = 1'b0, v65 = 1'b0, zeros = 1'b0, last = 1'b0;
  logic        res_ready = 1'b1;
  logic        r65 = 1'b1;

  logic        in_ready, res_valid, done, err, ovf;
  logic [71:0] res_data;
  logic [9:0]  res_row;
  logic        rdy65, rv65, done65, err65, ovf65;
  logic [64:0] d65;
  logic [9:0]  row65;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, done_dbl = 0;
  logic done_prev = 1'b0;
  logic [81:0] rq[$];
  logic [74:0] q65[$];

  always #5 clk = ~clk;

  spmv_row_accum dut (
    .clk(clk), .reset(rst_n), .in_op1(op1), .in_op2(op2), .in_addr(addr),
    .in_valid(v), .in_zeros(zeros), .in_last(last), .in_ready(in_ready),
    .res_data(res_data), .res_row(res_row), .res_valid(res_valid),
    .res_ready(res_ready), .done(done), .err(err), .ovf(ovf)
  );

  spmv_row_accum #(.ACC_W(65)) dut65 (
    .clk(clk), .reset(rst_n), .in_op1(op1), .in_op2(op2), .in_addr(addr),
    .in_valid(v65), .in_zeros(zeros), .in_last(last), .in_ready(rdy65),
    .res_data(d65), .res_row(row65), .res_valid(rv65),
    .res_ready(r65), .done(done65), .err(err65), .ovf(ovf65)
  );

  // A pop happens on the edge after a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (res_valid && res_ready) rq.push_back({res_row, res_data});
    if (rv65 && r65) q65.push_back({row65, d65});
    if (done) done_cnt++;
    if (done && done_prev) done_dbl++;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel65, input logic [63:0] a, input logic [63:0] b,
                      input logic [9:0] r, input bit z, input bit l, output int stalls);
    @(negedge clk);
    op1 = a; op2 = b; addr = r; zeros = z; last = l;
    if (sel65) v65 = 1'b1; else v = 1'b1;
    stalls = 0;
    while (!(sel65 ? rdy65 : in_ready) && stalls < 500) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 500) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    v = 1'b0; v65 = 1'b0;
  endtask

  task automatic wait_q(input string tag, input int n);
    int k = 0;
    while (rq.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rq.size(), n);
  endtask

  task automatic expect_res(input string tag, input logic [9:0] r, input logic [71:0] d);
    logic [81:0] e;
    e = (rq.size() != 0) ? rq.pop_front() : '1;
    chk({tag, "_row"}, e[81:72], r);
    chk({tag, "_sum"}, e[71:0], d);
  endtask

  initial begin
    int st, st2, d0;
    logic [74:0] e65;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_row", res_row, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // 1: row 3, (5,7) + (-2,0) -> {3,10}
    d0 = done_cnt;
    send(0, 64'd5, 64'd7, 10'd3, 0, 0, st);
    send(0, -64'sd2, 64'd0, 10'd3, 0, 1, st);
    wait_q("t1_count", 1);
    expect_res("t1", 10'd3, 72'd10);
    repeat (3) @(negedge clk);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_err", err, 0);

    // 2: row 0 data, row 1 empty, row 2 data last
    d0 = done_cnt;
    send(0, 64'd1, 64'd1, 10'd0, 0, 0, st);
    send(0, 64'd0, 64'd0, 10'd1, 1, 0, st);
    chk("t2_zero_beat_stall", st, 0);
    send(0, 64'd4, 64'd4, 10'd2, 0, 1, st2);
    chk("t2_zpend_stall", st2, 1);
    wait_q("t2_count", 3);
    expect_res("t2a", 10'd0, 72'd2);
    expect_res("t2b", 10'd1, 72'd0);
    expect_res("t2c", 10'd2, 72'd8);
    repeat (3) @(negedge clk);
    chk("t2_done", done_cnt - d0, 1);

    // 3: back-pressure with 12 single-beat rows
    d0 = done_cnt;
    @(posedge clk); #1 res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(0, 64'(i), 64'd1, 10'(i), 0, (i == 11), st);
      end
      begin
        repeat (40) @(negedge clk);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_none_popped", rq.size(), 0);
        @(posedge clk); #1 res_ready = 1'b1;
      end
    join
    wait_q("t3_count", 12);
    for (int i = 0; i < 12; i++) expect_res("t3", 10'(i), 72'(i + 1));
    repeat (4) @(negedge clk);
    chk("t3_no_extra", rq.size(), 0);
    chk("t3_done", done_cnt - d0, 1);

    // 4: row 5 then row 2 -> err sticky, both results emitted
    send(0, 64'd3, 64'd4, 10'd5, 0, 0, st);
    send(0, 64'd1, 64'd0, 10'd2, 0, 1, st);
    wait_q("t4_count", 2);
    expect_res("t4a", 10'd5, 72'd7);
    expect_res("t4b", 10'd2, 72'd1);
    repeat (5) @(negedge clk);
    chk("t4_err_sticky", err, 1);

    // 5: large products
    send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 10'd0, 0, 0, st);
    send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 10'd0, 0, 1, st);
    wait_q("t5_count", 1);
    expect_res("t5_w72", 10'd0, 72'h1_FFFF_FFFF_FFFF_FFFC);
    chk("t5_w72_ovf", ovf, 0);
    send(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 10'd0, 0, 0, st);
    send(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 10'd0, 0, 1, st);
    repeat (6) @(negedge clk);
    chk("t5_w65_count", q65.size(), 1);
    e65 = (q65.size() != 0) ? q65.pop_front() : '1;
`ifdef ACC_SAT_EN
    chk("t5_w65_sum", e65[64:0], 65'h0_FFFF_FFFF_FFFF_FFFF);
    chk("t5_w65_ovf", ovf65, 1);
`else
    chk("t5_w65_sum", e65[64:0], 65'h1_FFFF_FFFF_FFFF_FFFC);
    chk("t5_w65_ovf", ovf65, 0);
`endif

    // 6: reset mid-row with 3 FIFO entries
    @(posedge clk); #1 res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 64'd1, 64'd0, 10'(i), 0, 0, st);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", res_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    rq.delete();
    d0 = done_cnt;
    send(0, 64'd1, 64'd2, 10'd4, 0, 0, st);
    send(0, 64'd3, 64'd3, 10'd6, 0, 1, st);
    wait_q("t6_count", 2);
    expect_res("t6a", 10'd4, 72'd3);
    expect_res("t6b", 10'd6, 72'd6);
    repeat (4) @(negedge clk);
    chk("t6_no_extra", rq.size(), 0);
    chk("t6_done", done_cnt - d0, 1);
    chk("done_width", done_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
